// File: rtl/cu_multicycle.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with bounded req/ack waits.
// Define CU_MC_PERF_EN to build the retired-instruction counter behind instret_o.
module cu_multicycle #(
    parameter int ALU_OP_W = 4,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [6:0]          op_i,
    output logic                imem_req_o,
    input  logic                imem_ack_i,
    output logic                dmem_req_o,
    input  logic                dmem_ack_i,
    output logic                ir_write_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [2:0]          imm_select_o,
    output logic                alu_src_o,
    output logic                alu_pc_o,
    output logic                add_sum_reg_o,
    output logic                mem_to_reg_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    output logic                reg_write_o,
    output logic                branch_o,
    output logic                pc_write_o,
    output logic                trap_o,
    output logic [1:0]          trap_cause_o,
    output logic [CNT_W-1:0]    instret_o
);

    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] TMO_V = WCW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t r_state, w_next;

    logic [ALU_OP_W-1:0] r_alu_op, w_alu_op;
    logic [2:0]          r_imm, w_imm;
    logic                r_src, w_src;
    logic                r_pc, w_pc;
    logic                r_as, w_as;
    logic                r_m2r, w_m2r;
    logic                r_wr, w_wr;
    logic                r_br, w_br;
    logic                r_ld, w_ld;
    logic                r_st, w_st;
    logic                w_illegal;
    logic [1:0]          r_cause, w_cause;
    logic [WCW-1:0]      r_wcnt;
    logic                w_tmo;

    always_comb begin
        w_alu_op  = '0;
        w_imm     = 3'b000;
        w_src     = 1'b0;
        w_pc      = 1'b0;
        w_as      = 1'b0;
        w_m2r     = 1'b0;
        w_wr      = 1'b0;
        w_br      = 1'b0;
        w_ld      = 1'b0;
        w_st      = 1'b0;
        w_illegal = 1'b0;
        case (op_i)
            7'b0010011: begin
                w_alu_op = ALU_OP_W'(5); w_src = 1'b1; w_wr = 1'b1;
            end
            7'b0110011: begin
                w_wr = 1'b1;
            end
            7'b0110111: begin
                w_alu_op = ALU_OP_W'(1); w_imm = 3'b011;
                w_src = 1'b1; w_wr = 1'b1;
            end
            7'b0100011: begin
                w_alu_op = ALU_OP_W'(6); w_imm = 3'b001;
                w_src = 1'b1; w_st = 1'b1;
            end
            7'b0000011: begin
                w_alu_op = ALU_OP_W'(6); w_src = 1'b1;
                w_wr = 1'b1; w_m2r = 1'b1; w_ld = 1'b1;
            end
            7'b1100011: begin
                w_alu_op = ALU_OP_W'(2); w_imm = 3'b010; w_br = 1'b1;
            end
            7'b0010111: begin
                w_alu_op = ALU_OP_W'(4); w_imm = 3'b011;
                w_src = 1'b1; w_pc = 1'b1; w_wr = 1'b1;
            end
            7'b1101111: begin
                w_alu_op = ALU_OP_W'(3); w_imm = 3'b100;
                w_pc = 1'b1; w_wr = 1'b1; w_br = 1'b1;
            end
            7'b1100111: begin
                w_alu_op = ALU_OP_W'(3); w_pc = 1'b1;
                w_as = 1'b1; w_br = 1'b1;
            end
            7'b0000000: ;
            default: w_illegal = 1'b1;
        endcase
    end

    // TIMEOUT of 0 means wait forever
    assign w_tmo = (TIMEOUT != 0) && (r_wcnt == TMO_V);

    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        unique case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack_i) begin
                    w_next = S_DECODE;
                end else if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b01;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC:   w_next = (r_ld || r_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack_i) begin
                    w_next = S_WB;
                end else if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b11;
                end
            end
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cause <= 2'b00;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if ((r_state == S_FETCH && !imem_ack_i) ||
                (r_state == S_MEM && !dmem_ack_i)) begin
                if (r_wcnt != '1) r_wcnt <= r_wcnt + 1'b1;
            end else begin
                r_wcnt <= '0;
            end
        end
    end

    // selects are captured once per instruction and held until the next DECODE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alu_op <= '0;
            r_imm    <= 3'b000;
            r_src    <= 1'b0;
            r_pc     <= 1'b0;
            r_as     <= 1'b0;
            r_m2r    <= 1'b0;
            r_wr     <= 1'b0;
            r_br     <= 1'b0;
            r_ld     <= 1'b0;
            r_st     <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_alu_op <= w_alu_op;
            r_imm    <= w_imm;
            r_src    <= w_src;
            r_pc     <= w_pc;
            r_as     <= w_as;
            r_m2r    <= w_m2r;
            r_wr     <= w_wr;
            r_br     <= w_br;
            r_ld     <= w_ld;
            r_st     <= w_st;
        end
    end

    assign imem_req_o    = (r_state == S_FETCH);
    assign ir_write_o    = (r_state == S_FETCH) && imem_ack_i;
    assign dmem_req_o    = (r_state == S_MEM);
    assign mem_rd_o      = (r_state == S_MEM) && r_ld;
    assign mem_wr_o      = (r_state == S_MEM) && r_st;
    assign reg_write_o   = (r_state == S_WB) && r_wr;
    assign branch_o      = (r_state == S_WB) && r_br;
    assign pc_write_o    = (r_state == S_WB);
    assign trap_o        = (r_state == S_TRAP);
    assign trap_cause_o  = r_cause;
    assign alu_op_o      = r_alu_op;
    assign imm_select_o  = r_imm;
    assign alu_src_o     = r_src;
    assign alu_pc_o      = r_pc;
    assign add_sum_reg_o = r_as;
    assign mem_to_reg_o  = r_m2r;

`ifdef CU_MC_PERF_EN
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_instret <= '0;
        end else if (r_state == S_WB) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instret_o = r_instret;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed table-driven bench for cu_multicycle plus trap, timeout and reset sequences.
module tb_cu_multicycle;

    localparam int TMO = 15;
`ifdef CU_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  op_i = '0;
    logic        imem_req_o, imem_ack_i = 1'b0;
    logic        dmem_req_o, dmem_ack_i = 1'b0;
    logic        ir_write_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  imm_select_o;
    logic        alu_src_o, alu_pc_o, add_sum_reg_o, mem_to_reg_o;
    logic        mem_rd_o, mem_wr_o, reg_write_o, branch_o, pc_write_o;
    logic        trap_o;
    logic [1:0]  trap_cause_o;
    logic [31:0] instret_o;

    int n_tests = 0;
    int n_fail  = 0;

    cu_multicycle #(.ALU_OP_W(4), .TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i),
        .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack_i),
        .ir_write_o(ir_write_o), .alu_op_o(alu_op_o),
        .imm_select_o(imm_select_o), .alu_src_o(alu_src_o),
        .alu_pc_o(alu_pc_o), .add_sum_reg_o(add_sum_reg_o),
        .mem_to_reg_o(mem_to_reg_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .reg_write_o(reg_write_o),
        .branch_o(branch_o), .pc_write_o(pc_write_o),
        .trap_o(trap_o), .trap_cause_o(trap_cause_o),
        .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       src, pc, as, m2r, wr, br, ld, st;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {10'd0, imem_req_o, dmem_req_o, ir_write_o, alu_op_o,
                imm_select_o, alu_src_o, alu_pc_o, add_sum_reg_o,
                mem_to_reg_o, mem_rd_o, mem_wr_o, reg_write_o, branch_o,
                pc_write_o, trap_o, trap_cause_o, instret_o};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        op_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // entered at a negedge with the DUT in FETCH; leaves in the next FETCH
    task automatic run_instr(input vec_t v, input int k);
        int cyc = 0, fc = 0, mc = 0, n_im = 0, n_ir = 0, n_dm = 0;
        int n_rd = 0, n_wr = 0, n_rw = 0, n_br = 0, n_pc = 0;
        int bad_ir = 0, n_trap = 0, exp_cyc;
        bit done = 1'b0;
        op_i = v.op;
        while (!done && cyc < 200) begin
            imem_ack_i = imem_req_o && (fc == v.fw);
            dmem_ack_i = dmem_req_o && (mc == v.mw);
            #1;
            n_im   += int'(imem_req_o);
            n_ir   += int'(ir_write_o);
            n_dm   += int'(dmem_req_o);
            n_rd   += int'(mem_rd_o);
            n_wr   += int'(mem_wr_o);
            n_rw   += int'(reg_write_o);
            n_br   += int'(branch_o);
            n_pc   += int'(pc_write_o);
            n_trap += int'(trap_o);
            if (ir_write_o !== imem_ack_i) bad_ir++;
            if (imem_req_o) fc++;
            if (dmem_req_o) mc++;
            if (pc_write_o) done = 1'b1;
            cyc++;
            @(negedge clk_i);
        end
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        exp_cyc = 4 + v.fw + ((v.ld || v.st) ? 1 + v.mw : 0);
        chk($sformatf("i%0d cycles", k), cyc, exp_cyc);
        chk($sformatf("i%0d imem_req", k), n_im, v.fw + 1);
        chk($sformatf("i%0d ir_write", k), n_ir, 1);
        chk($sformatf("i%0d ir_vs_ack", k), bad_ir, 0);
        chk($sformatf("i%0d dmem_req", k), n_dm,
            (v.ld || v.st) ? v.mw + 1 : 0);
        chk($sformatf("i%0d mem_rd", k), n_rd, v.ld ? v.mw + 1 : 0);
        chk($sformatf("i%0d mem_wr", k), n_wr, v.st ? v.mw + 1 : 0);
        chk($sformatf("i%0d reg_write", k), n_rw, int'(v.wr));
        chk($sformatf("i%0d branch", k), n_br, int'(v.br));
        chk($sformatf("i%0d pc_write", k), n_pc, 1);
        chk($sformatf("i%0d trap", k), n_trap, 0);
        chk($sformatf("i%0d selects", k),
            {alu_op_o, imm_select_o, alu_src_o, alu_pc_o,
             add_sum_reg_o, mem_to_reg_o},
            {v.alu, v.imm, v.src, v.pc, v.as, v.m2r});
        chk($sformatf("i%0d instret", k), instret_o, PERF ? k + 1 : 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{7'b0010011, 0, 0, 4'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{7'b0000011, 0, 3, 4'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{7'b0100011, 1, 1, 4'd6, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{7'b1100111, 0, 0, 4'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{7'b0110011, 2, 0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{7'b0110111, 0, 0, 4'd1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{7'b1100011, 1, 0, 4'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{7'b0010111, 0, 0, 4'd4, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{7'b1101111, 3, 0, 4'd3, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{7'b0000000, 0, 0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #1;
        chk("reset_outs", all_outs(), 64'd0);

        do_reset();
        chk("fetch_after_idle", imem_req_o, 1'b1);
        for (int i = 0; i < 10; i++) run_instr(tbl[i], i);

        // illegal opcode traps and then ignores acks
        do_reset();
        op_i = 7'b1111111;
        imem_ack_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("illegal trap", trap_o, 1'b1);
        chk("illegal cause", trap_cause_o, 2'b01);
        n = 0;
        imem_ack_i = 1'b1;
        dmem_ack_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            #1;
            n += int'(imem_req_o || dmem_req_o || pc_write_o ||
                      reg_write_o || ir_write_o || !trap_o);
        end
        chk("trap held quiet", n, 0);
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;

        // fetch timeout with ack never arriving
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (trap_o) break;
            n += int'(imem_req_o);
            @(negedge clk_i);
        end
        chk("ftmo cycles", n, TMO + 1);
        chk("ftmo trap", trap_o, 1'b1);
        chk("ftmo cause", trap_cause_o, 2'b10);

        // ack on the boundary cycle wins over the timeout
        do_reset();
        op_i = 7'b0010011;
        for (int i = 0; i <= TMO; i++) begin
            imem_ack_i = (i == TMO);
            @(negedge clk_i);
        end
        imem_ack_i = 1'b0;
        #1;
        chk("fack_edge trap", trap_o, 1'b0);
        chk("fack_edge left fetch", imem_req_o, 1'b0);
        repeat (3) @(negedge clk_i);
        #1;
        chk("fack_edge refetch", imem_req_o, 1'b1);

        // data timeout
        do_reset();
        op_i = 7'b0000011;
        imem_ack_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (trap_o) break;
            n += int'(dmem_req_o);
            @(negedge clk_i);
        end
        chk("dtmo cycles", n, TMO + 1);
        chk("dtmo cause", trap_cause_o, 2'b11);

        // async reset in the middle of a data access
        do_reset();
        run_instr(tbl[0], 0);
        op_i = 7'b0000011;
        imem_ack_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("mid_mem req", dmem_req_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("mid_mem drop", dmem_req_o, 1'b0);
        chk("mid_mem outs", all_outs(), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("restart fetch", imem_req_o, 1'b1);
        chk("restart instret", instret_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Multicycle control unit for the RISC-V-lite core. It decodes the 7-bit opcode and sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. Instruction and data memory are accessed through req/ack handshakes with a bounded wait. The datapath mux selects are driven from a registered decode, and write strobes are asserted only in the proper state. It replaces the purely combinational decoder in front of the shared-ALU, multicycle datapath.

## Interface
Parameters:
- ALU_OP_W, 4, width of alu_op_o
- TIMEOUT, 15, max wait cycles for an ack; 0 disables the timeout
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- op_i  in  7  opcode field of the instruction register; valid from DECODE onward
- imem_req_o  out  1  instruction fetch request
- imem_ack_i  in  1  fetch complete; instruction captured this edge
- dmem_req_o  out  1  data access request
- dmem_ack_i  in  1  data access complete
- ir_write_o  out  1  one-cycle strobe that loads the instruction register
- alu_op_o  out  ALU_OP_W  ALU operation class
- imm_select_o  out  3  immediate format: 000 I, 001 S, 010 SB, 011 U, 100 UJ
- alu_src_o, alu_pc_o, add_sum_reg_o, mem_to_reg_o  out  1 each  datapath mux selects
- mem_rd_o, mem_wr_o  out  1 each  data read/write, asserted only in MEM
- reg_write_o  out  1  register file write strobe, asserted only in WB
- branch_o  out  1  branch/jump class, asserted only in WB
- pc_write_o  out  1  PC update strobe, asserted only in WB
- trap_o  out  1  core halted
- trap_cause_o  out  2  01 illegal opcode, 10 fetch timeout, 11 data timeout
- instret_o  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is IDLE. IDLE moves to FETCH on the first edge after reset is released.
- FETCH:
  - imem_req_o = 1.
  - On imem_ack_i: ir_write_o pulses in the same cycle, then go to DECODE.
- DECODE: register the decode of op_i, then go to EXEC. Opcode table (alu_op, imm_select, alu_src, alu_pc, add_sum_reg, writes register):
  - 0010011: 5, I, 1, 0, 0, writes
  - 0110011: 0, I, 0, 0, 0, writes
  - 0110111: 1, U, 1, 0, 0, writes
  - 0100011: 6, S, 1, 0, 0, no write
  - 0000011: 6, I, 1, 0, 0, writes; mem_to_reg = 1
  - 1100011: 2, SB, 0, 0, 0, no write; branch
  - 0010111: 4, U, 1, 1, 0, writes
  - 1101111: 3, UJ, 0, 1, 0, writes; branch
  - 1100111: 3, I, 0, 1, 1, no write; branch
  - 0000000: nop, all selects 0
  - Any other opcode: go to TRAP with cause 01.
- EXEC: one cycle. Loads and stores go to MEM; every other class goes to WB.
- MEM:
  - dmem_req_o = 1.
  - mem_rd_o = 1 for loads; mem_wr_o = 1 for stores.
  - On dmem_ack_i: go to WB.
- WB: one cycle.
  - reg_write_o = 1 only for classes that write a register.
  - branch_o = 1 for branch classes.
  - pc_write_o = 1 always.
  - instret_o increments; nop also retires.
  - Next state is FETCH.
- Mux selects hold their registered values from the cycle after DECODE until the next DECODE.
- Timeout:
  - A wait counter clears on entry to FETCH and MEM and increments each cycle without an ack.
  - When the counter equals TIMEOUT with no ack, go to TRAP with cause 10 (fetch) or 11 (data).
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins; no trap.
- TRAP:
  - trap_o = 1, all requests and strobes 0.
  - TRAP is held until reset.
- An ack received while the corresponding req is low is ignored.

## Timing
- Reset: every output is 0, including instret_o and trap_cause_o, and the state is IDLE. Reset takes effect immediately (asynchronous) in any state, including mid-handshake. A pending request drops the same cycle.
- Requests are Moore outputs (functions of state only). An ack is sampled on the rising edge while the request is high.
- Zero-wait memory (ack in the same cycle as req): non-memory instruction takes 4 cycles (FETCH, DECODE, EXEC, WB); load/store takes 5. Each wait cycle adds one.
- The wait counter is ceil(log2(TIMEOUT+1)) bits and saturates; there is no wrap.
- instret_o wraps modulo 2^CNT_W.

## Configuration
- CU_MC_PERF_EN defined: instret_o counter is implemented as described.
- CU_MC_PERF_EN undefined: no counter register; instret_o is tied to 0.
- All other behaviour is identical with and without the macro.

## Test plan
- Zero-wait addi (op 0010011):
  - ir_write_o pulses in FETCH.
  - alu_op_o = 5, alu_src_o = 1 after DECODE.
  - reg_write_o and pc_write_o are each 1 for exactly one cycle, 4 cycles after leaving IDLE.
  - instret_o = 1.
- lw with dmem_ack_i delayed 3 cycles:
  - dmem_req_o and mem_rd_o are high for 4 cycles.
  - mem_to_reg_o = 1.
  - reg_write_o pulses in WB; total latency 8 cycles.
- sw then jalr:
  - sw: mem_wr_o = 1 in MEM, reg_write_o stays 0.
  - jalr: add_sum_reg_o = 1, branch_o = 1 in WB, reg_write_o = 0.
- Opcode 1111111: after DECODE, trap_o = 1 and trap_cause_o = 01; no imem_req_o for 20 further cycles.
- Timeout, TIMEOUT = 15:
  - imem_ack_i held low: trap_o rises with trap_cause_o = 10 after 15 wait cycles.
  - Repeat with the ack arriving on the 15th cycle: no trap.
- Reset and counter:
  - Assert rst_i mid-MEM: dmem_req_o drops immediately; all outputs 0. After release, FETCH restarts and instret_o = 0.
  - With CU_MC_PERF_EN undefined, instret_o stays 0 after 10 instructions.
